// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
//   DE10-Lite board constants shared by the input conditioning logic.
//   N_SW / N_BTN      : number of slide switches and KEY push buttons.
//   CLK_HZ            : board system clock frequency.
//   TICK_CYCLES_1MS   : prescaler period giving a 1 ms debounce tick at CLK_HZ.
//   KEY_RELEASED      : idle (released) level of a KEY pin; KEYs are active-low.
//   SW_RESET_LEVEL    : level assumed for a switch while in reset.
// -----------------------------------------------------------------------------
package board_io_pkg;

  localparam int   N_SW            = 10;
  localparam int   N_BTN           = 2;
  localparam int   CLK_HZ          = 50_000_000;
  localparam int   TICK_CYCLES_1MS = CLK_HZ / 1000;

  localparam logic KEY_RELEASED    = 1'b1;
  localparam logic SW_RESET_LEVEL  = 1'b0;

endpackage : board_io_pkg

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   Synchronises one asynchronous pin and accepts a new level only after it has
//   disagreed with the accepted level for DB_TICKS consecutive debounce ticks.
//   Ports:
//     clk    in  system clock
//     rst_n  in  synchronous reset, active-low
//     raw    in  asynchronous pin
//     tick   in  shared debounce tick strobe (one clk cycle wide)
//     level  out accepted (debounced) level, registered
//     rise   out one-cycle pulse, registered with level, on accepted 0->1
//     fall   out one-cycle pulse, registered with level, on accepted 1->0
// -----------------------------------------------------------------------------
module debounce_bit
  import board_io_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_TICKS    = 10,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_p0[SYNC_STAGES-1];

  // Stage p0: synchroniser chain; reset to the idle level so no false
  // disagreement is seen right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  // Stage p1: qualification counter and accepted level. The counter only ever
  // reaches CNT_LAST because acceptance clears it, so it cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= RESET_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          level <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule : debounce_bit

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
//   Synchronises and debounces the DE10-Lite SW and KEY pins before they reach
//   the switch/button PIOs, and produces one-cycle change/press events.
//   Ports:
//     clk_clk          in  system clock
//     reset_reset_n    in  synchronous reset, active-low
//     sw_raw_i         in  asynchronous switch pins
//     btn_raw_i        in  asynchronous KEY pins (0 = pressed)
//     switch_export_o  out debounced switch levels
//     button_export_o  out debounced KEY levels, board polarity
//     sw_change_o      out one-cycle pulse on any debounced switch transition
//     btn_press_o      out one-cycle pulse on debounced press (1->0) only
//     tick_o           out one-cycle debounce tick strobe
// -----------------------------------------------------------------------------
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int N_SW        = board_io_pkg::N_SW,
  parameter int N_BTN       = board_io_pkg::N_BTN,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_CYCLES = TICK_CYCLES_1MS,
  parameter int DB_TICKS    = 10
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_SW-1:0]  sw_raw_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_SW-1:0]  switch_export_o,
  output logic [N_BTN-1:0] button_export_o,
  output logic [N_SW-1:0]  sw_change_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic             tick_o
);

  localparam int               PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic [PRE_W-1:0] presc;
  logic             tick;

  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;

  // Stage p0: shared free-running prescaler; tick is a decode of a register,
  // so no raw pin reaches tick_o combinationally.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick   = (presc == PRE_LAST);
  assign tick_o = tick;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_TICKS    (DB_TICKS),
      .RESET_LEVEL (SW_RESET_LEVEL)
    ) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (sw_raw_i[i]),
      .tick  (tick),
      .level (switch_export_o[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  for (genvar j = 0; j < N_BTN; j++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_TICKS    (DB_TICKS),
      .RESET_LEVEL (KEY_RELEASED)
    ) u_db (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (btn_raw_i[j]),
      .tick  (tick),
      .level (button_export_o[j]),
      .rise  (btn_rise[j]),
      .fall  (btn_fall[j])
    );
  end

  // Switches report both edges; KEYs are active-low so only a fall is a press
  // and a release (rise) is deliberately dropped.
  assign sw_change_o = sw_rise | sw_fall;
  assign btn_press_o = btn_fall;

  logic unused_btn_rise;
  assign unused_btn_rise = ^btn_rise;

endmodule : board_input_conditioner

// File: tb/tb_board_input_conditioner.sv
module tb_board_input_conditioner;

  localparam int N_SW  = 10;
  localparam int N_BTN = 2;
  localparam int NB    = N_SW + N_BTN;
  localparam int TICK  = 4;
  localparam int DB    = 3;
  localparam logic [NB-1:0] RST_LVL = {2'b11, 10'b0};

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  switch_export;
  logic [N_BTN-1:0] button_export;
  logic [N_SW-1:0]  sw_change;
  logic [N_BTN-1:0] btn_press;
  logic             tick;

  int checks = 0;
  int errors = 0;

  board_input_conditioner #(
    .N_SW        (N_SW),
    .N_BTN       (N_BTN),
    .SYNC_STAGES (2),
    .TICK_CYCLES (TICK),
    .DB_TICKS    (DB)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .sw_raw_i        (sw_raw),
    .btn_raw_i       (btn_raw),
    .switch_export_o (switch_export),
    .button_export_o (button_export),
    .sw_change_o     (sw_change),
    .btn_press_o     (btn_press),
    .tick_o          (tick)
  );

  always #5 clk = ~clk;

  // Reference model: a pin value is seen two clocks after it is sampled; each
  // bit counts ticks of continuous disagreement and accepts on the DB-th one.
  logic [NB-1:0] m_q0, m_q1, m_stable, m_rise, m_fall;
  int            m_run [NB];
  int            m_cyc;
  bit            m_tick_now;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q0 = RST_LVL; m_q1 = RST_LVL; m_stable = RST_LVL;
      m_rise = '0; m_fall = '0; m_cyc = 0;
      for (int b = 0; b < NB; b++) m_run[b] = 0;
    end else begin
      m_tick_now = (m_cyc == TICK - 1);
      m_rise = '0; m_fall = '0;
      for (int b = 0; b < NB; b++) begin
        if (m_q1[b] == m_stable[b]) m_run[b] = 0;
        else if (m_tick_now) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DB) begin
            m_stable[b] = m_q1[b];
            m_run[b] = 0;
            if (m_q1[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          end
        end
      end
      m_q1 = m_q0;
      m_q0 = {btn_raw, sw_raw};
      m_cyc = (m_cyc + 1) % TICK;
    end
  end

  function automatic logic [24:0] exp_vec();
    return {m_stable[9:0], m_stable[11:10], m_rise[9:0] | m_fall[9:0],
            m_fall[11:10], (m_cyc == TICK - 1)};
  endfunction

  wire [24:0] dut_vec = {switch_export, button_export, sw_change, btn_press, tick};

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw_raw = 10'($urandom); btn_raw = 2'($urandom);
    end
    @(negedge clk);
    checks++; if (switch_export !== 10'h000) begin errors++; $display("FAIL reset_sw: got %h want 000", switch_export); end
    checks++; if (button_export !== 2'b11) begin errors++; $display("FAIL reset_btn: got %b want 11", button_export); end
    checks++; if ({sw_change, btn_press} !== 12'h000) begin errors++; $display("FAIL reset_pulses: got %h want 000", {sw_change, btn_press}); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    sw_raw = '0; btn_raw = 2'b11; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0; bit seen = 0;
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL press_model: got %h want %h", dut_vec, exp_vec()); end
      if (btn_press[0]) pulses++;
      if (!seen && button_export[0] === 1'b0) begin
        seen = 1;
        checks++; if (btn_press[0] !== 1'b1) begin errors++; $display("FAIL press_pulse_align: got %b want 1", btn_press[0]); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL press_latency: export stayed %b want 0 within 15", button_export[0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (btn_press[0]) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulse_count: got %0d want 1", pulses); end
    btn_raw[0] = 1'b1; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL release_model: got %h want %h", dut_vec, exp_vec()); end
      if (btn_press[0]) pulses++;
    end
    checks++; if (button_export[0] !== 1'b1) begin errors++; $display("FAIL release_level: got %b want 1", button_export[0]); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL release_pulse: got %0d want 0", pulses); end
  endtask

  task automatic test_bounce();
    bit moved = 0; int pulses = 0;
    for (int t = 0; t < 20; t++) begin
      sw_raw[3] = ~sw_raw[3];
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bounce_model: got %h want %h", dut_vec, exp_vec()); end
        if (switch_export[3] !== 1'b0 || sw_change[3] !== 1'b0) moved = 1;
      end
    end
    checks++; if (moved) begin errors++; $display("FAIL bounce_hold: export or pulse moved, want export 0 and no pulse"); end
    sw_raw[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL settle_model: got %h want %h", dut_vec, exp_vec()); end
      if (sw_change[3]) pulses++;
    end
    checks++; if (switch_export[3] !== 1'b1) begin errors++; $display("FAIL settle_level: got %b want 1", switch_export[3]); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL settle_pulse_count: got %0d want 1", pulses); end
  endtask

  task automatic test_short_glitch();
    bit moved = 0; int guard = 0;
    // Start so that only two ticks fall inside the 11 cycles of disagreement.
    while (m_cyc != 2 && guard < 10) begin
      @(negedge clk); guard++;
    end
    checks++; if (m_cyc != 2) begin errors++; $display("FAIL glitch_align: phase %0d want 2", m_cyc); end
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch_model: got %h want %h", dut_vec, exp_vec()); end
      if (button_export[1] !== 1'b1 || btn_press[1] !== 1'b0) moved = 1;
    end
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL glitch_after_model: got %h want %h", dut_vec, exp_vec()); end
      if (button_export[1] !== 1'b1 || btn_press[1] !== 1'b0) moved = 1;
    end
    checks++; if (moved) begin errors++; $display("FAIL glitch_hold: export or press moved, want 1 and no pulse"); end
  endtask

  task automatic test_simultaneous();
    bit seen = 0;
    sw_raw = '0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    checks++; if (switch_export !== 10'h000) begin errors++; $display("FAIL simul_pre: got %h want 000", switch_export); end
    sw_raw = 10'h3FF;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL simul_model: got %h want %h", dut_vec, exp_vec()); end
      if (switch_export !== 10'h000) begin
        seen = 1;
        checks++; if (switch_export !== 10'h3FF) begin errors++; $display("FAIL simul_level: got %h want 3ff", switch_export); end
        checks++; if (sw_change !== 10'h3FF) begin errors++; $display("FAIL simul_pulse: got %h want 3ff", sw_change); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL simul_timeout: export %h want 3ff within 20", switch_export); end
    @(negedge clk);
    checks++; if (sw_change !== 10'h000) begin errors++; $display("FAIL simul_pulse_end: got %h want 000", sw_change); end
  endtask

  task automatic test_mid_reset();
    int guard = 0; int lat = 0; bit seen = 0;
    btn_raw[1] = 1'b0;
    while (m_run[11] != 2 && guard < 30) begin
      @(negedge clk); guard++;
    end
    checks++; if (m_run[11] != 2) begin errors++; $display("FAIL midrst_reach: ticks %0d want 2", m_run[11]); end
    checks++; if (button_export[1] !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", button_export[1]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL midrst_model: got %h want %h", dut_vec, exp_vec()); end
      if (button_export[1] === 1'b0) begin
        seen = 1; lat = i;
        checks++; if (btn_press[1] !== 1'b1) begin errors++; $display("FAIL midrst_pulse: got %b want 1", btn_press[1]); end
      end
    end
    checks++; if (!seen || lat < 10 || lat > 15) begin errors++; $display("FAIL midrst_latency: got %0d cycles want 10..15", lat); end
  endtask

  initial begin
    rst_n = 1'b0; sw_raw = '0; btn_raw = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_simultaneous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_board_input_conditioner
